jorb_redirect_seq: RTL and testbench

//  Sequences the PC redirect that follows a resolved jump/branch in EX.

---
 rtl/jorb_redirect_seq.sv | 120 ++++++++++++
 tb/tb_jorb_redirect_seq.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jorb_redirect_seq.sv
// Redirect sequencer for resolved jumps/branches in EX: issues one registered PC redirect,
// holds IF/ID flush over a drain window, squashes wrong-path EX results, keeps statistics.
module jorb_redirect_seq #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [4:0]       ctrl_JorB,
  input  logic [1:0]       flag_result,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             ex_squash,
  output logic             misalign_err,
  output logic             busy,
  output logic [CNT_W-1:0] jorb_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int DW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, REDIR, DRAIN} StateT;

  StateT         state;
  logic [DW-1:0] drainCnt;
  logic          taken;
  logic          isJorb;

  // Branch condition decode; unlisted funct3 codes fall back to the less-than flag.
  always_comb begin
    taken  = 1'b0;
    isJorb = ctrl_JorB[4] | ctrl_JorB[3];
    if (ctrl_JorB[4]) begin
      taken = 1'b1;
    end else if (ctrl_JorB[3]) begin
      case (ctrl_JorB[2:0])
        3'b000:  taken = flag_result[1];
        3'b001:  taken = ~flag_result[1];
        3'b110:  taken = flag_result[0];
        3'b111:  taken = ~flag_result[0];
        default: taken = flag_result[0];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      drainCnt       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_if       <= 1'b0;
      flush_id       <= 1'b0;
      ex_squash      <= 1'b0;
      misalign_err   <= 1'b0;
      busy           <= 1'b0;
      jorb_cnt       <= '0;
      taken_cnt      <= '0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (isJorb && (jorb_cnt != '1)) jorb_cnt <= jorb_cnt + CNT_W'(1);
            if (taken) begin
              if (ex_target[1:0] == 2'b00) begin
                state          <= REDIR;
                redirect_pc    <= ex_target;
                redirect_valid <= 1'b1;
                flush_if       <= 1'b1;
                flush_id       <= 1'b1;
                ex_squash      <= 1'b1;
                busy           <= 1'b1;
              end else begin
                misalign_err <= 1'b1;
              end
            end
          end
        end
        REDIR: begin
          if (redirect_ready) begin
            if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
            redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 1) begin
              state     <= IDLE;
              flush_if  <= 1'b0;
              flush_id  <= 1'b0;
              ex_squash <= 1'b0;
              busy      <= 1'b0;
            end else begin
              state    <= DRAIN;
              drainCnt <= DW'(FLUSH_CYCLES - 1);
            end
          end
        end
        DRAIN: begin
          // The cycle spent with the counter at 1 is the last flush cycle.
          if (drainCnt <= DW'(1)) begin
            state     <= IDLE;
            drainCnt  <= '0;
            flush_if  <= 1'b0;
            flush_id  <= 1'b0;
            ex_squash <= 1'b0;
            busy      <= 1'b0;
          end else begin
            drainCnt <= drainCnt - DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jorb_redirect_seq.sv
// Self-checking bench for jorb_redirect_seq: per-feature tasks plus a redirect-PC scoreboard
// popped on every accepted redirect; a second small-counter instance covers saturation.
module tb_jorb_redirect_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        satRst = 1'b1;
  logic        exValid = 1'b0;
  logic [4:0]  ctrlJorB = '0;
  logic [1:0]  flagResult = '0;
  logic [31:0] exTarget = '0;
  logic        redirectReady = 1'b0;

  logic        redirectValid, flushIf, flushId, exSquash, misalignErr, busy;
  logic [31:0] redirectPc;
  logic [15:0] jorbCnt, takenCnt;

  logic        satRedirectValid, satFlushIf, satFlushId, satExSquash, satMisalignErr, satBusy;
  logic [31:0] satRedirectPc;
  logic [3:0]  satJorbCnt, satTakenCnt;

  int checks = 0;
  int failures = 0;
  int expJorb = 0;
  int expTaken = 0;
  logic [31:0] expPcQ [$];

  logic [2:0] f3Tab   [9] = '{3'b000, 3'b001, 3'b110, 3'b110, 3'b111, 3'b111, 3'b100, 3'b101, 3'b010};
  logic [1:0] flagTab [9] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
  logic       takeTab [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  jorb_redirect_seq #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(exValid), .ctrl_JorB(ctrlJorB), .flag_result(flagResult),
    .ex_target(exTarget), .redirect_ready(redirectReady), .redirect_valid(redirectValid),
    .redirect_pc(redirectPc), .flush_if(flushIf), .flush_id(flushId), .ex_squash(exSquash),
    .misalign_err(misalignErr), .busy(busy), .jorb_cnt(jorbCnt), .taken_cnt(takenCnt)
  );

  jorb_redirect_seq #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(4)) dutSat (
    .clk(clk), .rst(satRst), .ex_valid(exValid), .ctrl_JorB(ctrlJorB), .flag_result(flagResult),
    .ex_target(exTarget), .redirect_ready(redirectReady), .redirect_valid(satRedirectValid),
    .redirect_pc(satRedirectPc), .flush_if(satFlushIf), .flush_id(satFlushId),
    .ex_squash(satExSquash), .misalign_err(satMisalignErr), .busy(satBusy),
    .jorb_cnt(satJorbCnt), .taken_cnt(satTakenCnt)
  );

  // Scoreboard: each accepted redirect must carry the next expected target.
  always @(negedge clk) begin
    if (!rst && redirectValid && redirectReady) begin
      checks++;
      if (expPcQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL sb_unexpected: redirect_pc=%h accepted, required none", redirectPc);
      end else begin
        logic [31:0] expPc;
        expPc = expPcQ.pop_front();
        if (redirectPc !== expPc) begin
          failures++;
          $display("[TB] FAIL sb_pc: redirect_pc=%h required %h", redirectPc, expPc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] c, input logic [1:0] f,
                               input logic [31:0] t);
    exValid    = v;
    ctrlJorB   = c;
    flagResult = f;
    exTarget   = t;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({redirectValid, flushIf, flushId, exSquash, misalignErr, busy} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctl: outputs=%b required 000000",
               {redirectValid, flushIf, flushId, exSquash, misalignErr, busy});
    end
    checks++;
    if ({redirectPc, jorbCnt, takenCnt} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: pc=%h jorb=%h taken=%h required 0", redirectPc, jorbCnt, takenCnt);
    end
  endtask

  task automatic test_beq();
    redirectReady = 1'b1;
    applyStimulus(1'b1, 5'b01000, 2'b10, 32'h100);
    expPcQ.push_back(32'h100);
    expJorb++;
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if ({redirectValid, flushIf, flushId, exSquash, busy} !== 5'b11111 || redirectPc !== 32'h100) begin
      failures++;
      $display("[TB] FAIL beq_redir: v/fi/fd/sq/busy=%b pc=%h required 11111 pc=00000100",
               {redirectValid, flushIf, flushId, exSquash, busy}, redirectPc);
    end
    tick();
    expTaken++;
    checks++;
    if ({redirectValid, flushIf, flushId, exSquash} !== 4'b0111 || takenCnt !== 16'(expTaken)) begin
      failures++;
      $display("[TB] FAIL beq_drain: v/fi/fd/sq=%b taken=%0d required 0111 taken=%0d",
               {redirectValid, flushIf, flushId, exSquash}, takenCnt, expTaken);
    end
    tick();
    checks++;
    if ({flushIf, flushId, busy} !== 3'b000 || jorbCnt !== 16'(expJorb)) begin
      failures++;
      $display("[TB] FAIL beq_idle: fi/fd/busy=%b jorb=%0d required 000 jorb=%0d",
               {flushIf, flushId, busy}, jorbCnt, expJorb);
    end
  endtask

  task automatic test_bne();
    applyStimulus(1'b1, 5'b01001, 2'b10, 32'h300);
    expJorb++;
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if (busy !== 1'b0 || redirectValid !== 1'b0 || jorbCnt !== 16'(expJorb) || takenCnt !== 16'(expTaken)) begin
      failures++;
      $display("[TB] FAIL bne_not_taken: busy=%b rv=%b jorb=%0d taken=%0d required 0 0 %0d %0d",
               busy, redirectValid, jorbCnt, takenCnt, expJorb, expTaken);
    end
  endtask

  task automatic test_decode();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, {2'b01, f3Tab[i]}, flagTab[i], 32'h1000 + 32'(i * 4));
      expJorb++;
      if (takeTab[i]) expPcQ.push_back(32'h1000 + 32'(i * 4));
      tick();
      applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
      checks++;
      if (busy !== takeTab[i]) begin
        failures++;
        $display("[TB] FAIL decode_%0d: busy=%b required %b (f3=%b flag=%b)",
                 i, busy, takeTab[i], f3Tab[i], flagTab[i]);
      end
      if (takeTab[i]) begin
        expTaken++;
        tick();
        tick();
      end
    end
    applyStimulus(1'b1, 5'b00111, 2'b01, 32'h2000);
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if (busy !== 1'b0 || jorbCnt !== 16'(expJorb) || takenCnt !== 16'(expTaken)) begin
      failures++;
      $display("[TB] FAIL decode_nonjorb: busy=%b jorb=%0d taken=%0d required 0 %0d %0d",
               busy, jorbCnt, takenCnt, expJorb, expTaken);
    end
  endtask

  task automatic test_stall();
    redirectReady = 1'b0;
    applyStimulus(1'b1, 5'b01111, 2'b00, 32'h204);
    expPcQ.push_back(32'h204);
    expJorb++;
    tick();
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h308);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) redirectReady = 1'b1;
      checks++;
      if (redirectValid !== 1'b1 || redirectPc !== 32'h204 || exSquash !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stall_hold_%0d: rv=%b pc=%h sq=%b required 1 00000204 1",
                 c, redirectValid, redirectPc, exSquash);
      end
      tick();
    end
    expTaken++;
    checks++;
    if (redirectValid !== 1'b0 || flushIf !== 1'b1 || jorbCnt !== 16'(expJorb) || takenCnt !== 16'(expTaken)) begin
      failures++;
      $display("[TB] FAIL stall_drain: rv=%b fi=%b jorb=%0d taken=%0d required 0 1 %0d %0d",
               redirectValid, flushIf, jorbCnt, takenCnt, expJorb, expTaken);
    end
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_misalign();
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h102);
    expJorb++;
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if (misalignErr !== 1'b1 || redirectValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL misalign_pulse: err=%b rv=%b busy=%b required 1 0 0", misalignErr, redirectValid, busy);
    end
    tick();
    checks++;
    if (misalignErr !== 1'b0 || takenCnt !== 16'(expTaken) || jorbCnt !== 16'(expJorb)) begin
      failures++;
      $display("[TB] FAIL misalign_after: err=%b taken=%0d jorb=%0d required 0 %0d %0d",
               misalignErr, takenCnt, jorbCnt, expTaken, expJorb);
    end
  endtask

  task automatic test_back_to_back();
    redirectReady = 1'b1;
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h3000);
    expPcQ.push_back(32'h3000);
    expJorb++;
    tick();
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h3100);
    tick();
    expTaken++;
    tick();
    checks++;
    if (redirectValid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_gap: rv=%b busy=%b required 0 0", redirectValid, busy);
    end
    expPcQ.push_back(32'h3100);
    expJorb++;
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if (redirectValid !== 1'b1 || redirectPc !== 32'h3100) begin
      failures++;
      $display("[TB] FAIL b2b_second: rv=%b pc=%h required 1 00003100", redirectValid, redirectPc);
    end
    tick();
    expTaken++;
    tick();
    checks++;
    if (jorbCnt !== 16'(expJorb) || takenCnt !== 16'(expTaken)) begin
      failures++;
      $display("[TB] FAIL b2b_counts: jorb=%0d taken=%0d required %0d %0d", jorbCnt, takenCnt, expJorb, expTaken);
    end
  endtask

  task automatic test_reset_mid();
    redirectReady = 1'b1;
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h400);
    expPcQ.push_back(32'h400);
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    tick();
    rst = 1'b1;
    applyStimulus(1'b1, 5'b10000, 2'b00, 32'h500);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    expJorb = 0;
    expTaken = 0;
    checks++;
    if ({redirectValid, flushIf, flushId, exSquash, misalignErr, busy} !== 6'b0 ||
        {redirectPc, jorbCnt, takenCnt} !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_mid: ctl=%b pc=%h jorb=%0d taken=%0d required all 0",
               {redirectValid, flushIf, flushId, exSquash, misalignErr, busy}, redirectPc, jorbCnt, takenCnt);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || redirectValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_after: busy=%b rv=%b required 0 0", busy, redirectValid);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    satRst = 1'b0;
    redirectReady = 1'b1;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 5'b01000, 2'b10, 32'h40);
      tick();
      applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
      if (i == 0) begin
        checks++;
        if (satRedirectValid !== 1'b1 || satRedirectPc !== 32'h40) begin
          failures++;
          $display("[TB] FAIL sat_redir: rv=%b pc=%h required 1 00000040", satRedirectValid, satRedirectPc);
        end
      end
      tick();
      if (i == 0) begin
        checks++;
        if ({satBusy, satFlushIf, satExSquash} !== 3'b000) begin
          failures++;
          $display("[TB] FAIL sat_flush1: busy/fi/sq=%b required 000", {satBusy, satFlushIf, satExSquash});
        end
      end
    end
    checks++;
    if (satJorbCnt !== 4'hF || satTakenCnt !== 4'hF) begin
      failures++;
      $display("[TB] FAIL sat_counts: jorb=%h taken=%h required F F", satJorbCnt, satTakenCnt);
    end
    applyStimulus(1'b1, 5'b01001, 2'b10, 32'h0);
    tick();
    applyStimulus(1'b0, 5'b0, 2'b0, 32'h0);
    checks++;
    if (satJorbCnt !== 4'hF) begin
      failures++;
      $display("[TB] FAIL sat_hold: jorb=%h required F", satJorbCnt);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_beq();
    test_bne();
    test_decode();
    test_stall();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    checks++;
    if (expPcQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: %0d redirects pending, required 0", expPcQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
